gate_in_debounce: RTL and testbench

GATE_IN_DEBOUNCE -- requirements
Module: gate_in_debounce

---
 rtl/gate_in_debounce.sv | 119 +++++++++++
 tb/tb_gate_in_debounce.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_in_debounce.sv
// Two-channel switch debouncer feeding a 2-input gate.
// Ports: clk, rst_n, a_raw/b_raw in; a/b levels, a_chg/b_chg pulses out.

module gate_in_debounce_ch #(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw,
  output logic q,
  output logic chg
);

  typedef enum logic {
    STABLE  = 1'b0,
    PENDING = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX =
    CNT_W'(STABLE_CNT - 1);

  state_t           state;
  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;

  // The STABLE->PENDING edge already counts as the first
  // disagreeing sample, so entry loads 1 and the toggle
  // lands STABLE_CNT edges after s2 first differs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1    <= 1'b0;
      s2    <= 1'b0;
      cnt   <= '0;
      q     <= 1'b0;
      chg   <= 1'b0;
      state <= STABLE;
    end else begin
      s1  <= raw;
      s2  <= s1;
      chg <= 1'b0;
      unique case (state)
        STABLE: begin
          if (s2 != q) begin
            if (CNT_MAX == '0) begin
              q   <= ~q;
              chg <= 1'b1;
            end else begin
              cnt   <= CNT_W'(1);
              state <= PENDING;
            end
          end
        end
        PENDING: begin
          if (s2 == q) begin
            cnt   <= '0;
            state <= STABLE;
          end else if (cnt == CNT_MAX) begin
            q     <= ~q;
            chg   <= 1'b1;
            cnt   <= '0;
            state <= STABLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= STABLE;
        end
      endcase
    end
  end

endmodule

module gate_in_debounce #(
  parameter int STABLE_CNT = 4,
  parameter int CNT_W      = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a_raw,
  input  logic b_raw,
  output logic a,
  output logic b,
  output logic a_chg,
  output logic b_chg
);

  if (STABLE_CNT < 1 ||
      STABLE_CNT > (1 << CNT_W)) begin : g_bad_param
    $error("gate_in_debounce: STABLE_CNT out of range");
  end

  gate_in_debounce_ch #(
    .STABLE_CNT(STABLE_CNT),
    .CNT_W     (CNT_W)
  ) u_ch_a (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (a_raw),
    .q    (a),
    .chg  (a_chg)
  );

  gate_in_debounce_ch #(
    .STABLE_CNT(STABLE_CNT),
    .CNT_W     (CNT_W)
  ) u_ch_b (
    .clk  (clk),
    .rst_n(rst_n),
    .raw  (b_raw),
    .q    (b),
    .chg  (b_chg)
  );

endmodule

// File: tb/tb_gate_in_debounce.sv
// Bench for gate_in_debounce at STABLE_CNT = 4.
// Expected {a,a_chg,b,b_chg} per cycle queued, popped after each edge.

module tb_gate_in_debounce;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic a_raw = 1'b0;
  logic b_raw = 1'b0;
  logic a;
  logic b;
  logic a_chg;
  logic b_chg;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q[$];
  logic [3:0] e;

  gate_in_debounce #(
    .STABLE_CNT(4),
    .CNT_W     (4)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .a_raw(a_raw),
    .b_raw(b_raw),
    .a    (a),
    .b    (b),
    .a_chg(a_chg),
    .b_chg(b_chg)
  );

  always #5 clk = ~clk;

  // Level starts at 0 and toggles at edges t1, t2 (-1 = never);
  // the change pulse is high only at the toggle edge itself.
  function automatic logic [1:0] ch_exp(int i, int t1, int t2);
    logic l1;
    logic l2;
    l1 = (t1 >= 0 && i >= t1);
    l2 = (t2 >= 0 && i >= t2);
    return {l1 ^ l2, (i == t1) || (i == t2)};
  endfunction

  task automatic push_exp(int n, int ta1, int ta2,
                          int tb1, int tb2);
    for (int i = 0; i < n; i++)
      exp_q.push_back({ch_exp(i, ta1, ta2),
                       ch_exp(i, tb1, tb2)});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    a_raw = 1'b0;
    b_raw = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({a, a_chg, b, b_chg} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_async got %b want 0000",
               {a, a_chg, b, b_chg});
    end
    a_raw = 1'b1;
    b_raw = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    checks++;
    if ({a, a_chg, b, b_chg} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_hold got %b want 0000",
               {a, a_chg, b, b_chg});
    end
    a_raw = 1'b0;
    b_raw = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(6, 5, -1, 5, -1);
    for (int i = 0; i < 6; i++) begin
      a_raw = 1'b1;
      b_raw = 1'b1;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({a, a_chg, b, b_chg} !== e) begin
        errors++;
        $display("FAIL reset_rel cyc%0d got %b want %b",
                 i, {a, a_chg, b, b_chg}, e);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a, a_chg, b, b_chg} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_mid got %b want 0000",
               {a, a_chg, b, b_chg});
    end
    do_reset();
  endtask

  task automatic test_rise_a();
    do_reset();
    push_exp(12, 7, -1, -1, -1);
    for (int i = 0; i < 12; i++) begin
      a_raw = (i >= 2);
      b_raw = 1'b0;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({a, a_chg, b, b_chg} !== e) begin
        errors++;
        $display("FAIL rise_a cyc%0d got %b want %b",
                 i, {a, a_chg, b, b_chg}, e);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    push_exp(14, -1, -1, -1, -1);
    for (int i = 0; i < 14; i++) begin
      a_raw = (i >= 2 && i <= 4);
      b_raw = (i == 6);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({a, a_chg, b, b_chg} !== e) begin
        errors++;
        $display("FAIL glitch cyc%0d got %b want %b",
                 i, {a, a_chg, b, b_chg}, e);
      end
    end
  endtask

  task automatic test_bounce();
    do_reset();
    push_exp(16, 10, -1, -1, -1);
    for (int i = 0; i < 16; i++) begin
      a_raw = (i >= 2 && i != 4);
      b_raw = 1'b0;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({a, a_chg, b, b_chg} !== e) begin
        errors++;
        $display("FAIL bounce cyc%0d got %b want %b",
                 i, {a, a_chg, b, b_chg}, e);
      end
    end
  endtask

  task automatic test_both();
    do_reset();
    push_exp(10, 7, -1, 7, -1);
    for (int i = 0; i < 10; i++) begin
      a_raw = (i >= 2);
      b_raw = (i >= 2);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({a, a_chg, b, b_chg} !== e) begin
        errors++;
        $display("FAIL both cyc%0d got %b want %b",
                 i, {a, a_chg, b, b_chg}, e);
      end
    end
  endtask

  task automatic test_fall();
    do_reset();
    push_exp(22, 7, 17, 9, -1);
    for (int i = 0; i < 22; i++) begin
      a_raw = (i >= 2 && i < 12);
      b_raw = (i >= 4);
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({a, a_chg, b, b_chg} !== e) begin
        errors++;
        $display("FAIL fall cyc%0d got %b want %b",
                 i, {a, a_chg, b, b_chg}, e);
      end
    end
  endtask

  task automatic test_reset_pending();
    do_reset();
    push_exp(4, -1, -1, -1, -1);
    for (int i = 0; i < 4; i++) begin
      a_raw = 1'b1;
      b_raw = 1'b0;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({a, a_chg, b, b_chg} !== e) begin
        errors++;
        $display("FAIL pend_pre cyc%0d got %b want %b",
                 i, {a, a_chg, b, b_chg}, e);
      end
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({a, a_chg} !== 2'b00) begin
      errors++;
      $display("FAIL pend_rst got %b want 00", {a, a_chg});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    push_exp(8, 5, -1, -1, -1);
    for (int i = 0; i < 8; i++) begin
      a_raw = 1'b1;
      b_raw = 1'b0;
      @(posedge clk);
      #1;
      e = exp_q.pop_front();
      checks++;
      if ({a, a_chg, b, b_chg} !== e) begin
        errors++;
        $display("FAIL pend_rel cyc%0d got %b want %b",
                 i, {a, a_chg, b, b_chg}, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rise_a();
    test_glitch();
    test_bounce();
    test_both();
    test_fall();
    test_reset_pending();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL queue_left got %0d want 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
